// File: rtl/m_fifo_pkg.sv
// rtl/m_fifo_pkg.sv - shared types and helpers for the m_fifo scheduler slice
// Purpose: scheduler state encoding and the wrapped round-robin increment.
// Contents: sched_state_e (IDLE/SERVE), rr_next(ptr, n).
package m_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } sched_state_e;

  // Increment modulo n; works for any n, not only powers of two.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/m_ff.sv
// rtl/m_ff.sv - generic register with asynchronous active-low reset
// Purpose: single place that defines how scheduler state is stored.
// Ports:
//   clk   in  1  clock
//   rst_n in  1  async active-low reset, loads RST
//   d     in  W  next value, captured every rising edge
//   q     out W  registered value
module m_ff #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/m_rr_pick.sv
// rtl/m_rr_pick.sv - combinational round-robin picker
// Purpose: first requester after ptr, searching ptr+1, ptr+2, ... mod N.
// Ports:
//   req   in  N          request vector
//   ptr   in  clog2(N)   last granted index
//   grant out clog2(N)   chosen index (0 when nothing requests)
//   any   out 1          at least one request present
module m_rr_pick
  import m_fifo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any
);

  localparam int L2N = $clog2(N);

  // The search walks the ring with rr_next and matches positions against the
  // loop index so req is only ever indexed by a constant after unrolling. The
  // last step of the walk lands back on ptr itself, so a lone requester that
  // was just served is found again.
  always_comb begin
    int   pos;
    logic found;
    grant = '0;
    found = 1'b0;
    pos   = int'(ptr);
    for (int k = 0; k < N; k++) begin
      pos = rr_next(pos, N);
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == pos)) begin
          found = 1'b1;
          grant = L2N'(i);
        end
      end
    end
    any = |req;
  end

endmodule

// File: rtl/m_fifo_rr_sched.sv
// rtl/m_fifo_rr_sched.sv - round-robin drain of N_SRC FIFOs into one registered stream
// Purpose: pops at most one non-empty source per cycle, bounded bursts per owner,
//          and registers the popped head into a valid/ready output.
// Ports:
//   clk        in  1            clock
//   rst_n      in  1            async active-low reset
//   src_empty  in  N_SRC        source FIFO empty flags
//   src_data   in  N_SRC*WIDTH  source FIFO heads, src i at [i*WIDTH +: WIDTH]
//   src_pop    out N_SRC        one-hot-or-zero pop strobes
//   out_valid  out 1            output register holds data
//   out_data   out WIDTH        registered data
//   out_src    out L2N          source index of out_data
//   out_ready  in  1            downstream accept
module m_fifo_rr_sched
  import m_fifo_pkg::*;
#(
  parameter int               N_SRC     = 4,
  parameter int               WIDTH     = 8,
  parameter int               BURST     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         src_empty,
  input  logic [N_SRC*WIDTH-1:0]   src_data,
  output logic [N_SRC-1:0]         src_pop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N_SRC)-1:0] out_src,
  input  logic                     out_ready
);

  localparam int             L2N       = $clog2(N_SRC);
  localparam int             L2B       = $clog2(BURST + 1);
  localparam logic [L2B-1:0] BURST_MAX = L2B'(BURST);
  localparam logic [L2N-1:0] PTR_RST   = L2N'(N_SRC - 1);

  sched_state_e     state_q, state_d;
  logic             state_raw;
  logic [L2N-1:0]   owner_q, owner_d;
  logic [L2B-1:0]   cnt_q, cnt_d;
  logic [L2N-1:0]   rr_q, rr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [L2N-1:0]   src_q, src_d;

  logic [N_SRC-1:0] req;
  logic [L2N-1:0]   rot_grant;
  logic [L2N-1:0]   grant;
  logic             any_req;
  logic             keep;
  logic             load;
  logic [WIDTH-1:0] src_word [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign src_word[g] = src_data[g*WIDTH +: WIDTH];
  end

  assign req = ~src_empty;

  m_rr_pick #(.N(N_SRC)) u_pick (
    .req   (req),
    .ptr   (rr_q),
    .grant (rot_grant),
    .any   (any_req)
  );

  // The current owner keeps the grant until its burst is used up or it runs dry.
  assign keep  = (state_q == SERVE) && req[owner_q] && (cnt_q < BURST_MAX);
  assign grant = keep ? owner_q : rot_grant;
  assign load  = (!valid_q || out_ready) && any_req;

  // State register
  m_ff #(.W(1),     .RST(1'b0))      u_state (.clk(clk), .rst_n(rst_n), .d(state_d), .q(state_raw));
  m_ff #(.W(L2N),   .RST('0))        u_owner (.clk(clk), .rst_n(rst_n), .d(owner_d), .q(owner_q));
  m_ff #(.W(L2B),   .RST('0))        u_cnt   (.clk(clk), .rst_n(rst_n), .d(cnt_d),   .q(cnt_q));
  m_ff #(.W(L2N),   .RST(PTR_RST))   u_rr    (.clk(clk), .rst_n(rst_n), .d(rr_d),    .q(rr_q));
  m_ff #(.W(1),     .RST(1'b0))      u_valid (.clk(clk), .rst_n(rst_n), .d(valid_d), .q(valid_q));
  m_ff #(.W(WIDTH), .RST(RESET_VAL)) u_data  (.clk(clk), .rst_n(rst_n), .d(data_d),  .q(data_q));
  m_ff #(.W(L2N),   .RST('0))        u_src   (.clk(clk), .rst_n(rst_n), .d(src_d),   .q(src_q));

  assign state_q = sched_state_e'(state_raw);

  // Next-state logic. A non-keep load covers both a new owner and the
  // exhausted-burst case where the rotate search lands on the owner again.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    if (load) begin
      state_d = SERVE;
      if (keep) begin
        cnt_d = (cnt_q == BURST_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        owner_d = grant;
        cnt_d   = L2B'(1);
        rr_d    = grant;
      end
    end else if ((state_q == SERVE) && !req[owner_q]) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs: pop strobe and output register update.
  always_comb begin
    src_pop = '0;
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    if (load) begin
      src_pop = {{(N_SRC-1){1'b0}}, 1'b1} << grant;
      valid_d = 1'b1;
      data_d  = src_word[grant];
      src_d   = grant;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;

  a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n) (src_pop & src_empty) == '0);

endmodule

// File: tb/tb_m_fifo_rr_sched.sv
// tb/tb_m_fifo_rr_sched.sv - self-checking bench for m_fifo_rr_sched
module tb_m_fifo_rr_sched;
  import m_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  e4, p4;
  logic [31:0] d4;
  logic        v4, r4;
  logic [7:0]  o4;
  logic [1:0]  s4;

  logic [2:0]  e3, p3;
  logic [23:0] d3;
  logic        v3, r3;
  logic [7:0]  o3;
  logic [1:0]  s3;

  m_fifo_rr_sched #(.N_SRC(4), .WIDTH(8), .BURST(4), .RESET_VAL(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .src_empty(e4), .src_data(d4), .src_pop(p4),
    .out_valid(v4), .out_data(o4), .out_src(s4), .out_ready(r4)
  );

  m_fifo_rr_sched #(.N_SRC(3), .WIDTH(8), .BURST(4), .RESET_VAL(8'h00)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .src_empty(e3), .src_data(d3), .src_pop(p3),
    .out_valid(v3), .out_data(o3), .out_src(s3), .out_ready(r3)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] fq [4][$];
  logic [7:0] eq [4][$];
  int         seq_no [4];
  bit         mode3 = 1'b0;
  logic [1:0] beat_src [$];
  int         beats, cyc, first_beat, last_beat, pop_on_empty;
  int         wait_c [3];
  int         max_wait;

  int exp_b [20] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1,0,0,1,1};

  typedef struct {
    logic [3:0] empty;
    logic       ready;
    logic [3:0] exp_pop;
    logic       exp_valid;
    logic [1:0] exp_src;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void drive();
    e4 = '1; d4 = '0; e3 = '1; d3 = '0;
    for (int i = 0; i < 4; i++) begin
      if (!mode3) begin
        e4[i] = (fq[i].size() == 0);
        if (fq[i].size() != 0) d4[i*8 +: 8] = fq[i][0];
      end else if (i < 3) begin
        e3[i] = (fq[i].size() == 0);
        if (fq[i].size() != 0) d3[i*8 +: 8] = fq[i][0];
      end
    end
  endfunction

  task automatic push(input int s, input int n);
    logic [7:0] w;
    for (int k = 0; k < n; k++) begin
      w = {2'(s), 6'(seq_no[s])};
      seq_no[s]++;
      fq[s].push_back(w);
      eq[s].push_back(w);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      fq[i].delete();
      eq[i].delete();
    end
    beat_src.delete();
    beats = 0; cyc = 0; first_beat = -1; last_beat = -1; pop_on_empty = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    r4 = 1'b1; r3 = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One cycle: sample at negedge, update source FIFO model after the edge.
  task automatic step();
    logic [3:0] pop, emp;
    logic       v, rdy;
    logic [1:0] s;
    logic [7:0] d;
    @(negedge clk);
    if (mode3) begin
      pop = {1'b0, p3}; emp = {1'b1, e3}; v = v3; rdy = r3; s = s3; d = o3;
    end else begin
      pop = p4; emp = e4; v = v4; rdy = r4; s = s4; d = o4;
    end
    if ((pop & emp) != 0) pop_on_empty++;
    if (v && rdy) begin
      beats++;
      beat_src.push_back(s);
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      total++;
      if (eq[s].size() == 0) begin
        bad++;
        $display("FAIL scoreboard: src %0d data %0h with nothing expected", s, d);
      end else begin
        if (eq[s][0] !== d || d[7:6] !== s) begin
          bad++;
          $display("FAIL scoreboard: src %0d data %0h want %0h", s, d, eq[s][0]);
        end
        void'(eq[s].pop_front());
      end
    end
    if (mode3 && pop != 0) begin
      for (int i = 0; i < 3; i++) begin
        if (pop[i] || emp[i]) wait_c[i] = 0;
        else begin
          wait_c[i]++;
          if (wait_c[i] > max_wait) max_wait = wait_c[i];
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++)
      if (pop[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    if (mode3) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(3) == 0 && fq[i].size() < 8) push(i, 1);
      r3 = ($urandom_range(9) < 7);
    end
    drive();
  endtask

  task automatic run_until(input string name, input int n, input int lim);
    for (int c = 0; c < lim && beats < n; c++) step();
    check({name, " beats"}, beats, n);
  endtask

  function automatic int eq_left();
    int t = 0;
    for (int i = 0; i < 4; i++) t += eq[i].size();
    return t;
  endfunction

  initial begin
    logic [7:0] held;

    vt[0] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    vt[1] = '{4'b1110, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    vt[2] = '{4'b0111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    vt[3] = '{4'b1001, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};
    vt[4] = '{4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 8'hA0};
    vt[5] = '{4'b1011, 1'b0, 4'b0100, 1'b1, 2'd2, 8'hC2};

    r4 = 1'b1; r3 = 1'b1;
    clear_model();
    drive();
    rst_n = 1'b0;
    #1;
    check("reset out_valid", v4, 0);
    check("reset out_data", o4, 0);
    check("reset out_src", s4, 0);
    check("reset state", u_dut.state_q, IDLE);
    check("reset rr_ptr", u_dut.rr_q, 3);
    check("reset cnt", u_dut.cnt_q, 0);

    // Table: first grant from IDLE for several empty patterns.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      e4 = vt[v].empty; d4 = 32'hD3C2B1A0; r4 = vt[v].ready;
      #1;
      check($sformatf("vec%0d pop", v), p4, vt[v].exp_pop);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d valid", v), v4, vt[v].exp_valid);
      check($sformatf("vec%0d src", v), s4, vt[v].exp_src);
      check($sformatf("vec%0d data", v), o4, vt[v].exp_data);
    end

    // All four sources with three words each.
    do_reset();
    for (int i = 0; i < 4; i++) push(i, 3);
    drive();
    run_until("seqA", 12, 40);
    for (int k = 0; k < 12 && k < beat_src.size(); k++)
      check($sformatf("seqA src%0d", k), beat_src[k], k / 3);
    check("seqA consecutive", last_beat - first_beat, 11);
    check("seqA pop on empty", pop_on_empty, 0);
    check("seqA leftover", eq_left(), 0);

    // Two sources, ten words each: bursts of four alternate.
    do_reset();
    push(0, 10); push(1, 10);
    drive();
    run_until("seqB", 20, 60);
    for (int k = 0; k < 20 && k < beat_src.size(); k++)
      check($sformatf("seqB src%0d", k), beat_src[k], exp_b[k]);

    // Lone source: burst wraps to the same owner, then back to IDLE.
    do_reset();
    push(2, 6);
    drive();
    run_until("seqC", 6, 30);
    for (int k = 0; k < 6 && k < beat_src.size(); k++)
      check($sformatf("seqC src%0d", k), beat_src[k], 2);
    check("seqC consecutive", last_beat - first_beat, 5);
    repeat (3) step();
    check("seqC idle", u_dut.state_q, IDLE);
    check("seqC cnt", u_dut.cnt_q, 0);

    // Five-cycle downstream stall mid-stream.
    do_reset();
    push(0, 6); push(1, 6);
    drive();
    repeat (4) step();
    r4 = 1'b0;
    held = o4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d valid", k), v4, 1);
      check($sformatf("stall%0d pop", k), p4, 0);
      check($sformatf("stall%0d data", k), o4, held);
      @(posedge clk);
      #1;
    end
    r4 = 1'b1;
    run_until("seqD", 12, 60);
    check("seqD leftover", eq_left(), 0);
    check("seqD pop on empty", pop_on_empty, 0);

    // Asynchronous reset between edges in the middle of a burst.
    do_reset();
    push(1, 8);
    drive();
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    clear_model();
    drive();
    #1;
    check("async rst valid", v4, 0);
    check("async rst pop", p4, 0);
    check("async rst data", o4, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(i, 2);
    drive();
    run_until("seqE", 1, 10);
    if (beat_src.size() > 0) check("seqE first src", beat_src[0], 0);

    // Three sources, random fill and random ready.
    mode3 = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) wait_c[i] = 0;
    max_wait = 0;
    for (int c = 0; c < 10000; c++) step();
    check("rand no starvation", (max_wait <= 8) ? 1 : 0, 1);
    check("rand pop on empty", pop_on_empty, 0);
    check("rand some beats", (beats > 1000) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
